// File: rtl/reg_view.sv
// Register-file viewer: snapshots one 16-bit register and multiplexes it as four
// hex digits on a 7-segment display, selected manually (step) or by auto-scan.
module reg_view #(
    parameter int REFRESH_DIV  = 1024,
    parameter int DWELL_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        auto,
    input  logic        step,
    output logic [2:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic [2:0]  cur_reg,
    output logic [3:0]  digit_an,
    output logic [6:0]  seg
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [7:0]       DWELL_MAX = 8'(DWELL_FRAMES - 1);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LATCH = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cur_reg_q, cur_reg_d;
    logic [15:0]      snap_q, snap_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       digit_q, digit_d;
    logic [7:0]       frame_q, frame_d;
    logic             step_q;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic div_wrap_s, frame_done_s, step_edge_s, auto_adv_s;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign rd_addr  = cur_reg_q;
    assign cur_reg  = cur_reg_q;
    assign digit_an = an_q;
    assign seg      = seg_q;

    // Next-state: refresh timing, fetch sequencing, register selection, display drive
    always_comb begin
        state_d   = state_q;
        cur_reg_d = cur_reg_q;
        snap_d    = snap_q;
        frame_d   = frame_q;

        div_wrap_s   = (div_q == DIV_MAX);
        div_d        = div_wrap_s ? '0 : div_q + DIV_W'(1);
        digit_d      = div_wrap_s ? digit_q + 2'd1 : digit_q;
        frame_done_s = div_wrap_s && (digit_q == 2'd3);
        step_edge_s  = step && !step_q;
        auto_adv_s   = (state_q == SHOW) && frame_done_s && auto && (frame_q == DWELL_MAX);

        case (state_q)
            FETCH:   state_d = LATCH;
            LATCH: begin
                state_d = SHOW;
                snap_d  = rd_data;
            end
            SHOW: begin
                if (frame_done_s) begin
                    state_d = FETCH;
                end else begin
                    state_d = SHOW;
                end
            end
            default: state_d = FETCH;
        endcase

        if (!auto) begin
            frame_d = 8'd0;
        end else if ((state_q == SHOW) && frame_done_s) begin
            frame_d = (frame_q == DWELL_MAX) ? 8'd0 : frame_q + 8'd1;
        end else begin
            frame_d = frame_q;
        end

        // A step edge and an auto-advance on the same cycle still move by one register
        if (step_edge_s || auto_adv_s) begin
            cur_reg_d = cur_reg_q + 3'd1;
            frame_d   = 8'd0;
        end else begin
            cur_reg_d = cur_reg_q;
        end

        if (step_edge_s) begin
            state_d = FETCH;
        end else begin
            state_d = state_d;
        end

        an_d  = ~(4'b0001 << digit_q);
        seg_d = hex_to_seg(snap_q[{digit_q, 2'b00} +: 4]);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            cur_reg_q <= 3'd0;
            snap_q    <= 16'd0;
            div_q     <= '0;
            digit_q   <= 2'd0;
            frame_q   <= 8'd0;
            step_q    <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
        end else begin
            state_q   <= state_d;
            cur_reg_q <= cur_reg_d;
            snap_q    <= snap_d;
            div_q     <= div_d;
            digit_q   <= digit_d;
            frame_q   <= frame_d;
            step_q    <= step;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

endmodule

// File: tb/tb_reg_view.sv
// Self-checking bench for reg_view: directed decode table, multi-cycle corner
// sequences and randomized traffic compared against a cycle-count based model.
module tb_reg_view;

    localparam int DIV   = 4;
    localparam int DWELL = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst, auto, step;
    logic [2:0]  rd_addr, cur_reg;
    logic [15:0] rd_data;
    logic [3:0]  digit_an;
    logic [6:0]  seg;
    logic [15:0] rf [8];

    int errors = 0;
    int checks = 0;

    // Reference model state: time since reset and cycles since last fetch start
    int          m_t, m_phase, m_frames;
    logic [2:0]  m_cur;
    logic [15:0] m_snap;
    logic        m_step_prev;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;

    always #5 clk = ~clk;

    assign rd_data = rf[rd_addr];

    reg_view #(.REFRESH_DIV(DIV), .DWELL_FRAMES(DWELL)) dut (
        .clk(clk), .rst(rst), .auto(auto), .step(step),
        .rd_addr(rd_addr), .rd_data(rd_data), .cur_reg(cur_reg),
        .digit_an(digit_an), .seg(seg)
    );

    typedef struct {
        logic [15:0] val;
        logic [6:0]  s0, s1, s2, s3;
    } dec_vec_t;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int digit;
        logic fd, show, edge_s, adv;
        if (rst) begin
            m_t = 0; m_phase = 0; m_frames = 0; m_cur = 3'd0; m_snap = 16'd0;
            m_step_prev = 1'b0; m_an = 4'b1111; m_seg = 7'b1111111;
        end else begin
            digit  = (m_t / DIV) % 4;
            fd     = ((m_t % FRAME) == FRAME - 1);
            show   = (m_phase >= 2);
            edge_s = step && !m_step_prev;
            adv    = show && fd && auto && (m_frames == DWELL - 1);
            m_an   = ~(4'b0001 << digit);
            m_seg  = ref_seg(4'((m_snap >> (4 * digit)) & 16'hF));
            if (m_phase == 1) m_snap = rf[m_cur];
            if (!auto) m_frames = 0;
            else if (edge_s || adv) m_frames = 0;
            else if (show && fd) m_frames = m_frames + 1;
            if (edge_s || adv) m_cur = m_cur + 3'd1;
            if (edge_s || (show && fd)) m_phase = 0;
            else if (m_phase < 2) m_phase = m_phase + 1;
            m_t = m_t + 1;
            m_step_prev = step;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("cyc_cur_reg", {13'd0, cur_reg}, {13'd0, m_cur});
        check("cyc_rd_addr", {13'd0, rd_addr}, {13'd0, m_cur});
        check("cyc_digit_an", {12'd0, digit_an}, {12'd0, m_an});
        check("cyc_seg", {9'd0, seg}, {9'd0, m_seg});
    endtask

    task automatic pulse_step();
        step = 1'b1; cycle();
        step = 1'b0; cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; cycle(); cycle();
        rst = 1'b0;
    endtask

    task automatic scan(input logic [6:0] e0, input logic [6:0] e1,
                        input logic [6:0] e2, input logic [6:0] e3);
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            case (m_an)
                4'b1110: check("dec_d0", {9'd0, seg}, {9'd0, e0});
                4'b1101: check("dec_d1", {9'd0, seg}, {9'd0, e1});
                4'b1011: check("dec_d2", {9'd0, seg}, {9'd0, e2});
                4'b0111: check("dec_d3", {9'd0, seg}, {9'd0, e3});
                default: ;
            endcase
        end
    endtask

    initial begin
        dec_vec_t   tbl [5];
        logic [3:0] an_exp;
        logic [2:0] base;
        int         waited;
        logic       found;

        tbl[0] = '{16'h3210, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
        tbl[1] = '{16'h7654, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
        tbl[2] = '{16'hBA98, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011};
        tbl[3] = '{16'hFEDC, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        tbl[4] = '{16'hA5C1, 7'b1111001, 7'b1000110, 7'b0010010, 7'b0001000};

        for (int i = 0; i < 8; i++) rf[i] = 16'd0;
        rst = 1'b1; auto = 1'b0; step = 1'b0;

        // Reset state and the first frame after release
        do_reset();
        check("rst_an", {12'd0, digit_an}, 16'h000F);
        check("rst_seg", {9'd0, seg}, 16'h007F);
        check("rst_cur", {13'd0, cur_reg}, 16'h0000);
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            an_exp = 4'b0001 << (i / DIV);
            check("rel_an", {12'd0, digit_an}, {12'd0, ~an_exp});
            check("rel_seg", {9'd0, seg}, 16'h0040);
        end

        // Hex decode table on register 0
        for (int v = 0; v < 4; v++) begin
            rf[0] = tbl[v].val;
            do_reset();
            repeat (34) cycle();
            scan(tbl[v].s0, tbl[v].s1, tbl[v].s2, tbl[v].s3);
        end

        // Manual selection of register 3
        rf[3] = tbl[4].val;
        do_reset();
        repeat (3) pulse_step();
        check("step3_cur", {13'd0, cur_reg}, 16'h0003);
        repeat (34) cycle();
        scan(tbl[4].s0, tbl[4].s1, tbl[4].s2, tbl[4].s3);

        // Held step advances exactly once, re-pulse advances again
        base = m_cur;
        step = 1'b1;
        repeat (20) cycle();
        check("held_step", {13'd0, cur_reg}, {13'd0, base + 3'd1});
        step = 1'b0;
        repeat (3) cycle();
        pulse_step();
        check("repulse", {13'd0, cur_reg}, {13'd0, base + 3'd2});

        // Auto-scan wrap 7 -> 0 with snapshot reload
        rf[0] = 16'h1234;
        for (int k = 0; k < 8 && m_cur != 3'd7; k++) pulse_step();
        check("pre_wrap_cur", {13'd0, cur_reg}, 16'h0007);
        auto = 1'b1;
        waited = 0;
        while (cur_reg != 3'd0 && waited < 100) begin
            cycle();
            waited++;
        end
        check("wrap_cur", {13'd0, cur_reg}, 16'h0000);
        check("wrap_rd_addr", {13'd0, rd_addr}, 16'h0000);
        repeat (4) cycle();
        scan(7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

        // Step edge coinciding with the auto-advance frame_done
        found = 1'b0;
        base  = 3'd0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (m_phase >= 2 && (m_t % FRAME) == FRAME - 1 && m_frames == DWELL - 1 && !m_step_prev) begin
                base = m_cur;
                step = 1'b1;
                cycle();
                step = 1'b0;
                found = 1'b1;
            end else begin
                cycle();
            end
        end
        check("collide_found", {15'd0, found}, 16'h0001);
        check("collide_cur", {13'd0, cur_reg}, {13'd0, base + 3'd1});
        repeat (40) cycle();
        auto = 1'b0;

        // Live update of the displayed register, then reset mid-frame
        for (int k = 0; k < 8 && m_cur != 3'd1; k++) pulse_step();
        rf[1] = 16'h0001;
        repeat (40) cycle();
        scan(7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000);
        rf[1] = 16'h00FF;
        repeat (19) cycle();
        scan(7'b0001110, 7'b0001110, 7'b1000000, 7'b1000000);
        repeat (5) cycle();
        check("pre_rst_cur", {13'd0, cur_reg}, 16'h0001);
        rst = 1'b1;
        cycle();
        check("mid_rst_an", {12'd0, digit_an}, 16'h000F);
        check("mid_rst_seg", {9'd0, seg}, 16'h007F);
        check("mid_rst_cur", {13'd0, cur_reg}, 16'h0000);
        rst = 1'b0;

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            rst  = ($urandom_range(0, 299) == 0);
            step = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) < 2) auto = ~auto;
            if ($urandom_range(0, 19) == 0) rf[$urandom_range(0, 7)] = 16'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_view.md
REG_VIEW -- requirements
Module: reg_view

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1024: clock cycles each digit is lit; legal range 2..65535.
REQ-002 SHALL have parameter DWELL_FRAMES, default 64: full 4-digit frames per register in auto-scan; legal range 1..255.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port auto  in  1  auto-scan enable; level.
REQ-006 SHALL have port step  in  1  manual advance request; synchronous to clk, rising edge significant.
REQ-007 SHALL have port rd_addr  out  3  register file read-port address.
REQ-008 SHALL have port rd_data  in  16  register file read-port data; combinational from rd_addr.
REQ-009 SHALL have port cur_reg  out  3  index of the register currently selected.
REQ-010 SHALL have port digit_an  out  4  digit enables, active-low; bit n lights digit n.
REQ-011 SHALL have port seg  out  7  segments gfedcba, active-low.

Function
REQ-012 SHALL drive rd_addr = cur_reg combinationally at all times.
REQ-013 SHALL implement FSM states FETCH, LATCH, SHOW: FETCH->LATCH unconditionally; LATCH->SHOW unconditionally; SHOW->FETCH on frame_done.
REQ-014 SHALL load the 16-bit snapshot register from rd_data on the single cycle the FSM is in LATCH; snapshot SHALL hold otherwise.
REQ-015 SHALL run a divider counter 0..REFRESH_DIV-1 and a 2-bit digit index in every state; the digit index SHALL increment, wrapping 3->0, when the divider wraps.
REQ-016 SHALL define frame_done = (digit index == 3) and (divider == REFRESH_DIV-1).
REQ-017 SHALL register digit_an and seg, updating one cycle after the digit index changes; digit n shows snapshot[4n+3:4n] with anode pattern: digit 0 = 1110, 1 = 1101, 2 = 1011, 3 = 0111.
REQ-018 SHALL encode hex to seg (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019 SHALL register step and detect a rising edge (step=1, previous step=0); a held step SHALL yield exactly one advance.
REQ-020 SHALL, on a step edge in any state, increment cur_reg modulo 8 (7->0), clear the frame counter, and force state FETCH on the next cycle.
REQ-021 SHALL count frame_done events in SHOW with a frame counter; with auto=1, when frame_done occurs at count DWELL_FRAMES-1, SHALL increment cur_reg modulo 8 and clear the counter; with auto=0, the counter SHALL hold at 0.
REQ-022 SHALL, when a step edge and auto-advance coincide, increment cur_reg by exactly one.
REQ-023 SHALL continue multiplexing the previous snapshot during FETCH and LATCH; no blanking SHALL occur.
REQ-024 SHALL re-fetch the current register every frame, so a changed register value is displayed no later than the next frame plus 3 cycles.

Reset
REQ-025 SHALL, while rst=1 at posedge clk, set state=FETCH, cur_reg=0, snapshot=0, divider=0, digit index=0, frame counter=0, step history=0, digit_an=4'b1111, seg=7'b1111111.
REQ-026 SHALL, with rst asserted mid-operation (any state, any count), abandon the operation and restart from the reset state; rst SHALL take priority over step and auto.

Verification (REFRESH_DIV=4, DWELL_FRAMES=2; frame = 16 cycles)
REQ-027 SHALL cover reset: R0 model=0; release rst -> rd_addr=0, LATCH on cycle 2, digit_an cycles 1110/1101/1011/0111 every 4 cycles, seg=1000000 on all digits.
REQ-028 SHALL cover decode: R3=16'hA5C1, auto=0, one step edge x3 -> cur_reg=3; after LATCH, digits 0..3 show 1111001, 1000110, 0010010, 0001000.
REQ-029 SHALL cover held step: step high for 20 cycles -> cur_reg advances exactly once; release and re-pulse -> advances once more.
REQ-030 SHALL cover auto-scan wrap: auto=1 from cur_reg=7 -> after 2 frames (32 cycles from SHOW entry) cur_reg=0, rd_addr=0, snapshot reloaded.
REQ-031 SHALL cover collision: step edge on the same cycle as the auto-advance frame_done -> cur_reg +1 only, frame counter=0, state FETCH next cycle.
REQ-032 SHALL cover live update and mid-frame reset: change R1 from 0001 to 00FF while displayed -> new value within one frame; assert rst mid-frame -> next cycle digit_an=1111, seg=1111111, cur_reg=0.
